bram_arbiter_u0: RTL and testbench
==================================

// Module: bram_arbiter_u0
// PURPOSE
//  Upstream arbiter for bram_controller_u0. Merges DMA and CPU-cache request
//  streams into the controller's single request port (WR/In_valid/Addr/Di/reader_sel).
//  Uses round-robin arbitration, one registered output stage, and per-requester
//  outstanding-read credit limits so returns never exceed consumer buffering.
// PARAMETERS
//  ADDR_W      13  request address width
//  DATA_W      32  write data width
//  MAX_RD_OUT  10  max outstanding reads per requester (covers 10T BRAM latency)
//  CNT_W       4   pending-counter width, = $clog2(MAX_RD_OUT+1)
// PORTS
//  clk             in   1       clock, all logic on posedge
//  rst             in   1       reset, synchronous, active-low (0 = reset)
//  dma_req_valid   in   1       DMA request valid
//  dma_req_ready   out  1       DMA request accepted this cycle
//  dma_req_wr      in   1       1 = write, 0 = read
//  dma_req_addr    in   ADDR_W  DMA address
//  dma_req_wdata   in   DATA_W  DMA write data
//  cpu_req_valid   in   1       CPU-cache request valid
//  cpu_req_ready   out  1       CPU-cache request accepted this cycle
//  cpu_req_wr      in   1       1 = write, 0 = read
//  cpu_req_addr    in   ADDR_W  CPU address
//  cpu_req_wdata   in   DATA_W  CPU write data
//  dma_in_valid    in   1       read-return pulse from controller (DMA)
//  cache_in_valid  in   1       read-return pulse from controller (CPU)
//  WR              out  1       to controller: write enable
//  In_valid        out  1       to controller: request valid
//  Addr            out  ADDR_W  to controller: address
//  Di              out  DATA_W  to controller: write data
//  reader_sel      out  1       to controller: 0 = DMA, 1 = CPU
//  dma_rd_pending  out  CNT_W   DMA reads in flight
//  cpu_rd_pending  out  CNT_W   CPU reads in flight
// BEHAVIOUR
//  - Reset: all outputs 0. Pending counters 0. last_grant = CPU, so DMA wins first tie.
//  - Eligibility: elig_x = x_req_valid & (x_req_wr | x_rd_pending < MAX_RD_OUT).
//    Writes never consume credit.
//  - Grant (combinational): both eligible -> requester != last_grant.
//    One eligible -> that one. None -> no grant.
//    x_req_ready = grant_x. Ready never asserts unless valid is high.
//  - Grants are mutually exclusive. last_grant updates only on a grant.
//  - Output register: on grant, the next edge loads In_valid=1 and
//    WR/Addr/Di/reader_sel from the winner. With no grant, In_valid<=0 and
//    WR/Addr/Di/reader_sel hold their values.
//    Latency: handshake in cycle t -> In_valid high in cycle t+1.
//    Throughput: 1 request/cycle.
//  - Counters: x_rd_pending +1 on a read grant, -1 on the x return pulse.
//    If both happen in the same cycle, the counter is unchanged.
//    A return with the counter at 0 is ignored (saturate at 0).
//    The counter never exceeds MAX_RD_OUT.
//  - Reset mid-operation: counters clear and In_valid clears on the next edge.
//    Returns for requests already in the controller are absorbed by
//    saturate-at-0.
//  - Arbiter does not reorder. The controller completes in issue order.
// TESTING
//  1 rst=0 for 2 cycles with both valids high -> both readys 0, all outputs 0;
//    after release, DMA is granted first.
//  2 DMA read only, addr 0x0010 at cycle t -> dma_req_ready=1 at t;
//    at t+1: In_valid=1, WR=0, Addr=0x0010, reader_sel=0; dma_rd_pending=1.
//  3 Both valid reads held 6 cycles -> grants alternate D,C,D,C,D,C;
//    In_valid=1 every cycle; each pending counter = 3.
//  4 DMA issues 10 reads, no returns -> 11th read has dma_req_ready=0 while CPU
//    is still granted; one dma_in_valid pulse -> DMA granted next cycle, pending=10.
//  5 dma_rd_pending=10, DMA write addr 0x0100 Di=0xDEADBEEF -> granted;
//    WR=1, Di=0xDEADBEEF; pending stays 10.
//  6 Read grant and cache_in_valid in the same cycle -> cpu_rd_pending unchanged;
//    rst=0 mid-burst -> pending=0 and In_valid=0 after the edge.

Source files
------------

// File: rtl/bram_arbiter_u0.sv
// Round-robin request arbiter in front of bram_controller_u0: merges DMA and CPU-cache
// requests onto one registered request port, with per-requester outstanding-read credits.
module bram_arbiter_u0 #(
    parameter int ADDR_W     = 13,
    parameter int DATA_W     = 32,
    parameter int MAX_RD_OUT = 10,
    parameter int CNT_W      = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_req_valid,
    output logic              dma_req_ready,
    input  logic              dma_req_wr,
    input  logic [ADDR_W-1:0] dma_req_addr,
    input  logic [DATA_W-1:0] dma_req_wdata,
    input  logic              cpu_req_valid,
    output logic              cpu_req_ready,
    input  logic              cpu_req_wr,
    input  logic [ADDR_W-1:0] cpu_req_addr,
    input  logic [DATA_W-1:0] cpu_req_wdata,
    input  logic              dma_in_valid,
    input  logic              cache_in_valid,
    output logic              WR,
    output logic              In_valid,
    output logic [ADDR_W-1:0] Addr,
    output logic [DATA_W-1:0] Di,
    output logic              reader_sel,
    output logic [CNT_W-1:0]  dma_rd_pending,
    output logic [CNT_W-1:0]  cpu_rd_pending
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RD_OUT);

    // 1 = CPU was granted last, so DMA wins the next tie
    logic last_grant_cpu;
    logic elig_dma, elig_cpu;
    logic grant_dma, grant_cpu;

    // A return against an empty counter is dropped so returns of requests
    // flushed by a mid-operation reset cannot underflow it.
    function automatic logic [CNT_W-1:0] next_pending(input logic [CNT_W-1:0] cnt,
                                                      input logic inc,
                                                      input logic ret);
        logic dec;
        dec = ret && (cnt != '0);
        if (inc && !dec)
            return cnt + 1'b1;
        else if (dec && !inc)
            return cnt - 1'b1;
        else
            return cnt;
    endfunction

    always_comb begin
        elig_dma      = dma_req_valid && (dma_req_wr || (dma_rd_pending < MAX_CNT));
        elig_cpu      = cpu_req_valid && (cpu_req_wr || (cpu_rd_pending < MAX_CNT));
        grant_dma     = rst && elig_dma && (!elig_cpu || last_grant_cpu);
        grant_cpu     = rst && elig_cpu && (!elig_dma || !last_grant_cpu);
        dma_req_ready = grant_dma;
        cpu_req_ready = grant_cpu;
    end

    // Output stage: one registered request toward the controller
    always_ff @(posedge clk) begin
        if (!rst) begin
            last_grant_cpu <= 1'b1;
            In_valid       <= 1'b0;
            WR             <= 1'b0;
            Addr           <= '0;
            Di             <= '0;
            reader_sel     <= 1'b0;
            dma_rd_pending <= '0;
            cpu_rd_pending <= '0;
        end else begin
            In_valid <= grant_dma || grant_cpu;
            if (grant_dma) begin
                last_grant_cpu <= 1'b0;
                WR             <= dma_req_wr;
                Addr           <= dma_req_addr;
                Di             <= dma_req_wdata;
                reader_sel     <= 1'b0;
            end else if (grant_cpu) begin
                last_grant_cpu <= 1'b1;
                WR             <= cpu_req_wr;
                Addr           <= cpu_req_addr;
                Di             <= cpu_req_wdata;
                reader_sel     <= 1'b1;
            end
            dma_rd_pending <= next_pending(dma_rd_pending, grant_dma && !dma_req_wr, dma_in_valid);
            cpu_rd_pending <= next_pending(cpu_rd_pending, grant_cpu && !cpu_req_wr, cache_in_valid);
        end
    end

endmodule

// File: tb/tb_bram_arbiter_u0.sv
// Directed bench for bram_arbiter_u0: reset, single grant, round-robin,
// credit limit, write bypass, simultaneous grant/return and mid-burst reset.
module tb_bram_arbiter_u0;

    localparam int ADDR_W = 13;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              dma_req_valid, dma_req_ready, dma_req_wr;
    logic [ADDR_W-1:0] dma_req_addr;
    logic [DATA_W-1:0] dma_req_wdata;
    logic              cpu_req_valid, cpu_req_ready, cpu_req_wr;
    logic [ADDR_W-1:0] cpu_req_addr;
    logic [DATA_W-1:0] cpu_req_wdata;
    logic              dma_in_valid, cache_in_valid;
    logic              WR, In_valid, reader_sel;
    logic [ADDR_W-1:0] Addr;
    logic [DATA_W-1:0] Di;
    logic [CNT_W-1:0]  dma_rd_pending, cpu_rd_pending;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    bram_arbiter_u0 #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_RD_OUT(10), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst),
        .dma_req_valid(dma_req_valid), .dma_req_ready(dma_req_ready), .dma_req_wr(dma_req_wr),
        .dma_req_addr(dma_req_addr), .dma_req_wdata(dma_req_wdata),
        .cpu_req_valid(cpu_req_valid), .cpu_req_ready(cpu_req_ready), .cpu_req_wr(cpu_req_wr),
        .cpu_req_addr(cpu_req_addr), .cpu_req_wdata(cpu_req_wdata),
        .dma_in_valid(dma_in_valid), .cache_in_valid(cache_in_valid),
        .WR(WR), .In_valid(In_valid), .Addr(Addr), .Di(Di), .reader_sel(reader_sel),
        .dma_rd_pending(dma_rd_pending), .cpu_rd_pending(cpu_rd_pending)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // advance one edge; inputs change and outputs are sampled 1ns after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle_inputs();
        dma_req_valid = 0; dma_req_wr = 0; dma_req_addr = '0; dma_req_wdata = '0;
        cpu_req_valid = 0; cpu_req_wr = 0; cpu_req_addr = '0; cpu_req_wdata = '0;
        dma_in_valid = 0; cache_in_valid = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 0;
        tick();
        rst = 1;
    endtask

    initial begin
        idle_inputs();
        rst = 0;
        #1;

        // reset with both requesters asking
        dma_req_valid = 1; dma_req_addr = 13'h0AA;
        cpu_req_valid = 1; cpu_req_addr = 13'h0BB;
        tick();
        tick();
        settle();
        check("rst_dma_ready", dma_req_ready, 0);
        check("rst_cpu_ready", cpu_req_ready, 0);
        check("rst_in_valid", In_valid, 0);
        check("rst_addr", Addr, 0);
        check("rst_pending", {dma_rd_pending, cpu_rd_pending}, 0);
        rst = 1;
        settle();
        check("first_tie_dma_ready", dma_req_ready, 1);
        check("first_tie_cpu_ready", cpu_req_ready, 0);
        tick();
        check("first_tie_sel", reader_sel, 0);
        check("first_tie_addr", Addr, 13'h0AA);

        // single DMA read
        do_reset();
        dma_req_valid = 1; dma_req_wr = 0; dma_req_addr = 13'h0010;
        settle();
        check("t2_ready", dma_req_ready, 1);
        tick();
        dma_req_valid = 0;
        check("t2_in_valid", In_valid, 1);
        check("t2_wr", WR, 0);
        check("t2_addr", Addr, 13'h0010);
        check("t2_sel", reader_sel, 0);
        check("t2_pending", dma_rd_pending, 1);
        tick();
        check("t2_idle_in_valid", In_valid, 0);
        check("t2_idle_addr_hold", Addr, 13'h0010);

        // round-robin with both reading
        do_reset();
        dma_req_valid = 1; dma_req_addr = 13'h0100;
        cpu_req_valid = 1; cpu_req_addr = 13'h0200;
        for (int i = 0; i < 6; i++) begin
            settle();
            check("rr_dma_ready", dma_req_ready, (i % 2) == 0);
            check("rr_cpu_ready", cpu_req_ready, (i % 2) == 1);
            tick();
            check("rr_in_valid", In_valid, 1);
            check("rr_sel", reader_sel, i % 2);
            check("rr_addr", Addr, (i % 2) ? 13'h0200 : 13'h0100);
        end
        check("rr_dma_pending", dma_rd_pending, 3);
        check("rr_cpu_pending", cpu_rd_pending, 3);

        // DMA credit limit
        do_reset();
        dma_req_valid = 1; dma_req_addr = 13'h0040;
        for (int i = 0; i < 10; i++) tick();
        check("cred_pending10", dma_rd_pending, 10);
        cpu_req_valid = 1; cpu_req_addr = 13'h0300;
        settle();
        check("cred_dma_blocked", dma_req_ready, 0);
        check("cred_cpu_granted", cpu_req_ready, 1);
        tick();
        check("cred_cpu_sel", reader_sel, 1);
        cpu_req_valid = 0;
        dma_in_valid  = 1;
        settle();
        check("cred_still_blocked", dma_req_ready, 0);
        tick();
        dma_in_valid = 0;
        check("cred_pending9", dma_rd_pending, 9);
        settle();
        check("cred_dma_regrant", dma_req_ready, 1);
        tick();
        check("cred_pending_back10", dma_rd_pending, 10);
        check("cred_regrant_sel", reader_sel, 0);

        // write at full read credit
        dma_req_wr = 1; dma_req_addr = 13'h0100; dma_req_wdata = 32'hDEADBEEF;
        settle();
        check("wr_ready", dma_req_ready, 1);
        tick();
        dma_req_valid = 0; dma_req_wr = 0;
        check("wr_wr", WR, 1);
        check("wr_di", Di, 32'hDEADBEEF);
        check("wr_addr", Addr, 13'h0100);
        check("wr_pending", dma_rd_pending, 10);

        // grant and return together, then mid-burst reset
        do_reset();
        cache_in_valid = 1;
        tick();
        cache_in_valid = 0;
        check("sat_zero", cpu_rd_pending, 0);
        cpu_req_valid = 1; cpu_req_addr = 13'h0055;
        tick();
        check("cpu_pending1", cpu_rd_pending, 1);
        cache_in_valid = 1;
        tick();
        cache_in_valid = 0;
        check("both_unchanged", cpu_rd_pending, 1);
        tick();
        check("cpu_pending2", cpu_rd_pending, 2);
        rst = 0;
        tick();
        check("midrst_pending", cpu_rd_pending, 0);
        check("midrst_in_valid", In_valid, 0);
        rst = 1;
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
